// File: rtl/i3c_target_data_engine_pkg.sv
// Shared constants for the I3C target SDR data engine: byte width and
// target-side state encodings (TGT_ prefix keeps them apart from the
// controller's own state names).
package i3c_target_data_engine_pkg;

  localparam int TGT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    TGT_IDLE    = 3'd0,
    TGT_WR_BITS = 3'd1,
    TGT_WR_TBIT = 3'd2,
    TGT_RD_BITS = 3'd3,
    TGT_RD_TBIT = 3'd4,
    TGT_DONE    = 3'd5
  } tgt_state_e;

endpackage

// File: rtl/i3c_target_data_engine.sv
// I3C target SDR data engine. After a matched address phase it either
// deserialises controller-written bytes (checking the odd-parity T-bit) or
// serialises bytes from a valid/ready source, using the T-bit as the
// end-of-data marker. All outputs are registered.
module i3c_target_data_engine
  import i3c_target_data_engine_pkg::*;
#(
  parameter int DATA_WIDTH = TGT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scl_rise_i,
  input  logic                  scl_fall_i,
  input  logic                  stop_i,
  input  logic                  restart_i,
  input  logic                  xfer_start_i,
  input  logic                  is_read_i,
  input  logic                  sda_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  sda_o,
  output logic                  sda_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  parity_err_o,
  output logic                  underrun_o,
  output logic                  busy_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tgt_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sda_d, oe_d;
  logic [DATA_WIDTH-1:0] rx_data_d;
  logic                  rx_valid_d, perr_d, ready_d, underrun_d;
  logic                  rise, fall;

  // Simultaneous rise and fall strobes are illegal; such a cycle is dropped.
  assign rise = scl_rise_i & ~scl_fall_i;
  assign fall = scl_fall_i & ~scl_rise_i;

  // State register; asynchronous reset also releases SDA at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TGT_IDLE;
    else         state_q <= state_d;
  end

  // Registered outputs and bit counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      sda_o        <= 1'b1;
      sda_oe_o     <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      tx_ready_o   <= 1'b0;
      underrun_o   <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sda_o        <= sda_d;
      sda_oe_o     <= oe_d;
      rx_data_o    <= rx_data_d;
      rx_valid_o   <= rx_valid_d;
      parity_err_o <= perr_d;
      tx_ready_o   <= ready_d;
      underrun_o   <= underrun_d;
      busy_o       <= (state_d != TGT_IDLE);
    end
  end

  // Shift register is pure data; its contents only matter once loaded.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  // Next-state and next-output logic; STOP/Sr overrides every SCL strobe.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sda_d      = sda_o;
    oe_d       = sda_oe_o;
    rx_data_d  = rx_data_o;
    rx_valid_d = 1'b0;
    perr_d     = 1'b0;
    ready_d    = 1'b0;
    underrun_d = 1'b0;
    if (stop_i || restart_i) begin
      state_d = TGT_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        TGT_IDLE: begin
          if (xfer_start_i) begin
            cnt_d = '0;
            if (!is_read_i) begin
              state_d = TGT_WR_BITS;
            end else if (tx_valid_i) begin
              shift_d = tx_data_i;
              ready_d = 1'b1;
              sda_d   = tx_data_i[DATA_WIDTH-1];
              oe_d    = 1'b1;
              state_d = TGT_RD_BITS;
            end else begin
              underrun_d = 1'b1;
              state_d    = TGT_DONE;
            end
          end
        end
        TGT_WR_BITS: begin
          if (rise) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], sda_i};
            if (cnt_q == LAST_BIT) begin
              cnt_d   = '0;
              state_d = TGT_WR_TBIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        TGT_WR_TBIT: begin
          if (rise) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            perr_d     = ~(^{shift_q, sda_i});
            cnt_d      = '0;
            state_d    = TGT_WR_BITS;
          end
        end
        TGT_RD_BITS: begin
          if (fall) begin
            shift_d = shift_q << 1;
            if (cnt_q == LAST_BIT) begin
              cnt_d   = '0;
              sda_d   = tx_valid_i;
              state_d = TGT_RD_TBIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              sda_d = shift_q[DATA_WIDTH-2];
            end
          end
        end
        TGT_RD_TBIT: begin
          // The T-bit currently on SDA decides whether another byte follows.
          if (fall) begin
            if (sda_o) begin
              shift_d = tx_data_i;
              ready_d = 1'b1;
              sda_d   = tx_data_i[DATA_WIDTH-1];
              state_d = TGT_RD_BITS;
            end else begin
              oe_d    = 1'b0;
              sda_d   = 1'b1;
              state_d = TGT_DONE;
            end
          end
        end
        TGT_DONE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = TGT_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

endmodule
